// File: rtl/im_arbiter.sv
// im_arbiter: shares the single combinational read port of the instruction
// memory between the fetch unit (f_*) and the debug/boot port (d_*).
// Fetch has priority; a saturating starvation counter forces a debug win
// after STARVE_LIM consecutive contested cycles lost by debug. Responses
// come back one cycle after the grant on a per-requester channel, with
// alignment and range errors flagged instead of memory data.
module im_arbiter #(
  parameter int DEPTH_WORDS = 256,
  parameter int STARVE_LIM  = 4
) (
  input  logic        clk,
  input  logic        rst,

  input  logic        f_req,
  input  logic [31:0] f_addr,
  output logic        f_gnt,
  output logic        f_rvalid,
  output logic [31:0] f_rdata,
  output logic        f_err,

  input  logic        d_req,
  input  logic [31:0] d_addr,
  output logic        d_gnt,
  output logic        d_rvalid,
  output logic [31:0] d_rdata,
  output logic        d_err,

  output logic [31:0] im_addr,
  input  logic [31:0] im_instr
);

  // STARVE_LIM is limited to 1..15, so four bits always hold the count.
  logic [3:0]  starve_cnt_reg;
  logic [31:0] held_addr_reg;

  logic        contested;
  logic        force_debug;
  logic        any_gnt;
  logic [31:0] win_addr;
  logic [31:0] win_word;
  logic        win_err;
  logic [31:0] win_data;

  // Arbitration, address mux and error check for the current cycle.
  always_comb begin
    contested   = f_req & d_req;
    force_debug = (starve_cnt_reg == 4'(STARVE_LIM));

    // Reset suppresses any grant so no response can be launched from it.
    f_gnt = ~rst & f_req & ~(d_req & force_debug);
    d_gnt = ~rst & d_req & (~f_req | force_debug);

    any_gnt  = f_gnt | d_gnt;
    win_addr = f_gnt ? f_addr : d_addr;
    im_addr  = any_gnt ? win_addr : held_addr_reg;

    win_word = {2'b00, win_addr[31:2]};
    win_err  = (win_addr[1:0] != 2'b00) || (win_word >= 32'(DEPTH_WORDS));
    // Erroring accesses never expose memory contents.
    win_data = win_err ? 32'h0 : im_instr;
  end

  // Response registers, held address and starvation counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      f_rvalid       <= 1'b0;
      f_rdata        <= 32'h0;
      f_err          <= 1'b0;
      d_rvalid       <= 1'b0;
      d_rdata        <= 32'h0;
      d_err          <= 1'b0;
      starve_cnt_reg <= 4'd0;
      held_addr_reg  <= 32'h0;
    end else begin
      f_rvalid <= f_gnt;
      d_rvalid <= d_gnt;

      // The idle side keeps its last data/err; rvalid qualifies them.
      if (f_gnt) begin
        f_rdata <= win_data;
        f_err   <= win_err;
      end
      if (d_gnt) begin
        d_rdata <= win_data;
        d_err   <= win_err;
      end

      if (any_gnt) begin
        held_addr_reg <= win_addr;
      end

      // Only a contested loss by debug ages the counter; any debug win clears it.
      if (d_gnt) begin
        starve_cnt_reg <= 4'd0;
      end else if (contested && f_gnt && (starve_cnt_reg < 4'(STARVE_LIM))) begin
        starve_cnt_reg <= starve_cnt_reg + 4'd1;
      end
    end
  end

endmodule

// File: tb/tb_im_arbiter.sv
// Directed testbench for im_arbiter with a behavioural instruction memory.
module tb_im_arbiter;

  logic        clk;
  logic        rst;
  logic        f_req;
  logic [31:0] f_addr;
  logic        f_gnt;
  logic        f_rvalid;
  logic [31:0] f_rdata;
  logic        f_err;
  logic        d_req;
  logic [31:0] d_addr;
  logic        d_gnt;
  logic        d_rvalid;
  logic [31:0] d_rdata;
  logic        d_err;
  logic [31:0] im_addr;
  logic [31:0] im_instr;

  logic [31:0] mem [256];

  int checks;
  int errors;

  im_arbiter #(
    .DEPTH_WORDS(256),
    .STARVE_LIM (4)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .f_req   (f_req),
    .f_addr  (f_addr),
    .f_gnt   (f_gnt),
    .f_rvalid(f_rvalid),
    .f_rdata (f_rdata),
    .f_err   (f_err),
    .d_req   (d_req),
    .d_addr  (d_addr),
    .d_gnt   (d_gnt),
    .d_rvalid(d_rvalid),
    .d_rdata (d_rdata),
    .d_err   (d_err),
    .im_addr (im_addr),
    .im_instr(im_instr)
  );

  // Combinational-read instruction memory.
  assign im_instr = mem[im_addr[9:2]];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance to just after the next rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; f_req = 1'b1; f_addr = 32'h8; d_req = 1'b0; d_addr = 32'h0;
    #1;
    checks++;
    if (f_gnt !== 1'b0) begin errors++; $display("FAIL reset_f_gnt actual=%b required=0", f_gnt); end
    step();
    checks++;
    if ({f_rvalid, d_rvalid, f_err, d_err} !== 4'b0000) begin
      errors++; $display("FAIL reset_flags actual=%b required=0000", {f_rvalid, d_rvalid, f_err, d_err});
    end
    checks++;
    if (f_rdata !== 32'h0 || d_rdata !== 32'h0) begin
      errors++; $display("FAIL reset_rdata actual=%h/%h required=0/0", f_rdata, d_rdata);
    end
    checks++;
    if (im_addr !== 32'h0) begin errors++; $display("FAIL reset_im_addr actual=%h required=0", im_addr); end
    rst = 1'b0; f_req = 1'b0;
    step();
    $display("reset: done");
  endtask

  task automatic test_fetch_single();
    f_req = 1'b1; f_addr = 32'h4;
    #1;
    checks++;
    if (f_gnt !== 1'b1 || d_gnt !== 1'b0) begin
      errors++; $display("FAIL single_gnt actual=%b%b required=10", f_gnt, d_gnt);
    end
    checks++;
    if (im_addr !== 32'h4) begin errors++; $display("FAIL single_im_addr actual=%h required=4", im_addr); end
    step();
    f_req = 1'b0;
    checks++;
    if (f_rvalid !== 1'b1 || f_rdata !== 32'hDEADBEEF || f_err !== 1'b0 || d_rvalid !== 1'b0) begin
      errors++; $display("FAIL single_resp actual=v%b d%h e%b dv%b required=v1 dDEADBEEF e0 dv0",
                         f_rvalid, f_rdata, f_err, d_rvalid);
    end
    $display("fetch_single: addr=4 rdata=%h", f_rdata);
    step();
    checks++;
    if (f_rvalid !== 1'b0) begin errors++; $display("FAIL single_pulse actual=%b required=0", f_rvalid); end
  endtask

  task automatic test_fetch_stream();
    logic [31:0] exp_words [4];
    exp_words[0] = 32'hA000_0000;
    exp_words[1] = 32'hDEADBEEF;
    exp_words[2] = 32'hA000_0002;
    exp_words[3] = 32'hA000_0003;
    for (int i = 0; i < 4; i++) begin
      f_req = 1'b1; f_addr = 32'(i * 4);
      #1;
      checks++;
      if (im_addr !== 32'(i * 4)) begin
        errors++; $display("FAIL stream_im_addr[%0d] actual=%h required=%h", i, im_addr, i * 4);
      end
      step();
      checks++;
      if (f_rvalid !== 1'b1 || f_rdata !== exp_words[i] || f_err !== 1'b0) begin
        errors++; $display("FAIL stream_resp[%0d] actual=v%b d%h e%b required=v1 d%h e0",
                           i, f_rvalid, f_rdata, f_err, exp_words[i]);
      end
      $display("fetch_stream: beat %0d rdata=%h", i, f_rdata);
    end
    f_req = 1'b0;
    step();
    checks++;
    if (f_rvalid !== 1'b0) begin errors++; $display("FAIL stream_end actual=%b required=0", f_rvalid); end
  endtask

  task automatic test_contention();
    logic exp_d;
    f_req = 1'b1; f_addr = 32'h20; d_req = 1'b1; d_addr = 32'h24;
    for (int k = 0; k < 10; k++) begin
      // Counter starts at 0: four fetch wins, then debug, repeating.
      exp_d = (k % 5 == 4);
      #1;
      checks++;
      if (f_gnt !== ~exp_d || d_gnt !== exp_d) begin
        errors++; $display("FAIL contend_gnt[%0d] actual=%b%b required=%b%b", k, f_gnt, d_gnt, ~exp_d, exp_d);
      end
      step();
      checks++;
      if (d_rvalid !== exp_d || f_rvalid !== ~exp_d) begin
        errors++; $display("FAIL contend_rvalid[%0d] actual=f%b d%b required=f%b d%b",
                           k, f_rvalid, d_rvalid, ~exp_d, exp_d);
      end
      if (exp_d) begin
        checks++;
        if (d_rdata !== 32'hA000_0009 || d_err !== 1'b0) begin
          errors++; $display("FAIL contend_d_rdata[%0d] actual=%h required=a0000009", k, d_rdata);
        end
      end
      $display("contention: cycle %0d grant=%s", k, exp_d ? "d" : "f");
    end
    f_req = 1'b0; d_req = 1'b0;
    step();
  endtask

  task automatic test_errors();
    logic [31:0] addrs   [4];
    logic        exp_err [4];
    logic [31:0] exp_dat [4];
    addrs[0] = 32'h6;   exp_err[0] = 1'b1; exp_dat[0] = 32'h0;
    addrs[1] = 32'h400; exp_err[1] = 1'b1; exp_dat[1] = 32'h0;
    addrs[2] = 32'h8;   exp_err[2] = 1'b0; exp_dat[2] = 32'hA000_0002;
    addrs[3] = 32'h3FC; exp_err[3] = 1'b0; exp_dat[3] = 32'hA000_00FF;
    for (int i = 0; i < 4; i++) begin
      d_req = 1'b1; d_addr = addrs[i];
      step();
      checks++;
      if (d_rvalid !== 1'b1 || d_err !== exp_err[i] || d_rdata !== exp_dat[i]) begin
        errors++; $display("FAIL err_resp[%h] actual=v%b e%b d%h required=v1 e%b d%h",
                           addrs[i], d_rvalid, d_err, d_rdata, exp_err[i], exp_dat[i]);
      end
      $display("errors: d_addr=%h err=%b rdata=%h", addrs[i], d_err, d_rdata);
    end
    d_req = 1'b0;
    // Fetch side must still hold its last response (word 8 from contention).
    checks++;
    if (f_rvalid !== 1'b0 || f_rdata !== 32'hA000_0008 || f_err !== 1'b0) begin
      errors++; $display("FAIL err_f_hold actual=v%b d%h required=v0 da0000008", f_rvalid, f_rdata);
    end
    step();
  endtask

  task automatic test_reset_in_grant();
    f_req = 1'b1; f_addr = 32'hC; rst = 1'b1;
    #1;
    checks++;
    if (f_gnt !== 1'b0) begin errors++; $display("FAIL rstgnt_f_gnt actual=%b required=0", f_gnt); end
    step();
    checks++;
    if (f_rvalid !== 1'b0 || d_rvalid !== 1'b0 || f_rdata !== 32'h0 || d_rdata !== 32'h0 ||
        f_err !== 1'b0 || d_err !== 1'b0 || im_addr !== 32'h0) begin
      errors++; $display("FAIL rstgnt_outputs actual=fv%b dv%b fd%h dd%h fe%b de%b ia%h required=all zero",
                         f_rvalid, d_rvalid, f_rdata, d_rdata, f_err, d_err, im_addr);
    end
    rst = 1'b0; f_req = 1'b0;
    step();
    checks++;
    if (f_rvalid !== 1'b0) begin errors++; $display("FAIL rstgnt_no_resp actual=%b required=0", f_rvalid); end
    $display("reset_in_grant: done");
  endtask

  task automatic test_idle_hold();
    // Two contested fetch wins (counter 0 -> 2).
    f_req = 1'b1; f_addr = 32'h10; d_req = 1'b1; d_addr = 32'h14;
    step();
    step();
    // Fetch only: counter must stay at 2.
    d_req = 1'b0;
    step();
    // Idle.
    f_req = 1'b0;
    #1;
    checks++;
    if (im_addr !== 32'h10 || f_gnt !== 1'b0 || d_gnt !== 1'b0) begin
      errors++; $display("FAIL idle_im_addr actual=%h g%b%b required=10 g00", im_addr, f_gnt, d_gnt);
    end
    step();
    step();
    checks++;
    if (f_rvalid !== 1'b0 || d_rvalid !== 1'b0 || im_addr !== 32'h10) begin
      errors++; $display("FAIL idle_hold actual=fv%b dv%b ia%h required=0 0 10", f_rvalid, d_rvalid, im_addr);
    end
    $display("idle_hold: im_addr=%h", im_addr);
    // Contest again: counter 2 -> 3 -> 4, so f, f, then d.
    f_req = 1'b1; d_req = 1'b1;
    for (int k = 0; k < 3; k++) begin
      #1;
      checks++;
      if (d_gnt !== (k == 2) || f_gnt !== (k != 2)) begin
        errors++; $display("FAIL idle_counter[%0d] actual=%b%b required=%b%b", k, f_gnt, d_gnt, k != 2, k == 2);
      end
      step();
    end
    f_req = 1'b0; d_req = 1'b0;
    step();
  endtask

  initial begin
    checks = 0;
    errors = 0;
    for (int i = 0; i < 256; i++) mem[i] = 32'hA000_0000 + 32'(i);
    mem[1] = 32'hDEADBEEF;
    rst = 1'b1; f_req = 1'b0; f_addr = 32'h0; d_req = 1'b0; d_addr = 32'h0;
    step();
    test_reset();
    test_fetch_single();
    test_fetch_stream();
    test_contention();
    test_errors();
    test_reset_in_grant();
    test_idle_hold();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/im_arbiter.md
Name: im_arbiter

Overview:
- Shares the single read port of the 256-word instruction memory between two requesters: the core fetch unit (port f_*) and the debug/boot inspection port (port d_*).
- Fetch has priority. A starvation counter guarantees that debug is served.
- The block checks alignment and address range, and returns read data with a fixed one-cycle latency on a per-requester response channel.
- It sits between the fetch stage / debug unit and the combinational-read instruction memory.

Parameters:
- DEPTH_WORDS, 256, number of 32-bit words in the instruction memory; a byte address is valid when addr>>2 < DEPTH_WORDS.
- STARVE_LIM, 4, number of consecutive contested cycles lost by debug before debug is forced to win; range 1..15.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- rst  in  1  synchronous, active-high reset.
- f_req  in  1  fetch read request; held with f_addr until granted.
- f_addr  in  32  fetch byte address.
- f_gnt  out  1  combinational; fetch request accepted this cycle.
- f_rvalid  out  1  registered; fetch response valid; one-cycle pulse per grant.
- f_rdata  out  32  registered; fetch read data.
- f_err  out  1  registered; fetch response is an error (misaligned or out of range); valid with f_rvalid.
- d_req  in  1  debug read request.
- d_addr  in  32  debug byte address.
- d_gnt  out  1  combinational; debug request accepted this cycle.
- d_rvalid  out  1  registered; debug response valid.
- d_rdata  out  32  registered; debug read data.
- d_err  out  1  registered; debug error flag.
- im_addr  out  32  byte address to the instruction memory.
- im_instr  in  32  combinational read data from the instruction memory for im_addr.

Behaviour:
- Reset: synchronous, active-high; the following values apply at the first edge with rst=1.
  - f_rvalid, d_rvalid, f_err, d_err = 0.
  - f_rdata, d_rdata = 32'h0.
  - Starvation counter = 0.
  - Held address register = 0.
  - f_gnt and d_gnt are forced to 0 while rst=1.
- Arbitration, evaluated each cycle:
  - Only f_req: f_gnt=1.
  - Only d_req: d_gnt=1.
  - Both requesting ("contested" cycle): f_gnt=1 unless the counter equals STARVE_LIM, in which case d_gnt=1.
  - At most one grant per cycle. f_gnt and d_gnt are never both 1.
- Starvation counter:
  - A contested cycle that fetch wins increments the counter.
  - Any cycle where debug is granted clears the counter.
  - An uncontested cycle without a debug grant (fetch only, or idle) leaves the counter unchanged.
  - The counter saturates at STARVE_LIM.
- Address mux:
  - im_addr = the winning requester's address when a grant is issued.
  - Otherwise im_addr = the held register, which is the last granted address, or 0 after reset.
  - The held register loads the winning address on every grant.
- Response, with a latency of exactly 1 cycle:
  - On the edge following a grant, the granted side's rvalid=1 for one cycle.
  - If no grant is issued in the next cycle, rvalid returns to 0.
  - Back-to-back grants to the same side produce back-to-back rvalid pulses with no bubbles.
  - Full throughput: one access per cycle.
- Error check, applied to the granted address:
  - Condition: addr[1:0] != 0, or (addr>>2) >= DEPTH_WORDS.
  - On error: the response carries err=1 and rdata=32'h0; im_instr is ignored.
  - On success: rdata = im_instr as sampled in the grant cycle, and err=0.
- The non-responding side's rdata and err hold their last values; they are qualified only by rvalid.
- Requests are level-sensitive. A requester not granted keeps its req and addr stable; the block does not queue requests.
- Reset mid-operation: a grant issued in the same cycle as rst=1 is suppressed and no response is produced. A response due in the cycle after a reset edge is dropped.

Test Plan:
- Fetch alone, instruction memory preloaded with word[1]=32'hDEADBEEF: f_req=1, f_addr=32'h4 → f_gnt=1 in the same cycle; next cycle f_rvalid=1, f_rdata=32'hDEADBEEF, f_err=0; d_rvalid stays 0.
- Streaming fetch over addresses 0,4,8,12 on consecutive cycles → four consecutive f_rvalid pulses carrying word[0..3] in order; im_addr tracks each address.
- Both requesting continuously with STARVE_LIM=4 → grant pattern f,f,f,f,d repeating; counter returns to 0 after each debug grant; d_rvalid pulses every 5th cycle.
- Error cases:
  - d_addr=32'h6 (misaligned) → d_rvalid=1, d_err=1, d_rdata=0.
  - d_addr=32'h400 (word 256, out of range) → d_err=1, d_rdata=0.
  - Following d_addr=32'h8 → d_err=0 with correct data.
- Reset in grant cycle: f_req=1 with rst=1 asserted in that cycle → f_gnt=0, no f_rvalid on the next edge, and all outputs at reset values.
- Idle after access: a grant to 32'h10, then both req=0 → im_addr holds 32'h10; no rvalid; counter unchanged.
